// File: rtl/axi_ram_slave_pkg.sv
// Shared AXI definitions for the RAM responder: bus widths, response/burst codes, FSM states.
// Zero latency, no backpressure: definitions and a range-check helper only.
package axi_ram_slave_pkg;

  localparam int AXI_ADDR_W  = 64;
  localparam int AXI_DATA_W  = 64;
  localparam int AXI_STRB_W  = AXI_DATA_W / 8;
  localparam int AXI_LEN_W   = 8;
  localparam int AXI_SIZE_W  = 3;
  localparam int AXI_BURST_W = 2;
  localparam int AXI_RESP_W  = 2;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'b00,
    W_DATA = 2'b01,
    W_RESP = 2'b10
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

  // Start address must lie in [base, base + bytes); the subtraction cannot underflow once addr >= base.
  function automatic logic in_window(input logic [AXI_ADDR_W-1:0] addr,
                                     input logic [AXI_ADDR_W-1:0] base,
                                     input logic [AXI_ADDR_W-1:0] bytes);
    return (addr >= base) && ((addr - base) < bytes);
  endfunction

endpackage

// File: rtl/axi_ram_slave_if.sv
// AXI4 AW/W/B/AR/R signal bundle between the core's master port and the RAM responder.
// Pure wiring: no latency; flow control is the per-channel valid/ready handshake.
interface axi_ram_slave_if
  import axi_ram_slave_pkg::*;
#(
  parameter int ID_W = 4
);

  logic                   awvalid;
  logic                   awready;
  logic [ID_W-1:0]        awid;
  logic [AXI_ADDR_W-1:0]  awaddr;
  logic [AXI_LEN_W-1:0]   awlen;
  logic [AXI_SIZE_W-1:0]  awsize;
  logic [AXI_BURST_W-1:0] awburst;

  logic                   wvalid;
  logic                   wready;
  logic [AXI_DATA_W-1:0]  wdata;
  logic [AXI_STRB_W-1:0]  wstrb;
  logic                   wlast;

  logic                   bvalid;
  logic                   bready;
  logic [ID_W-1:0]        bid;
  logic [AXI_RESP_W-1:0]  bresp;

  logic                   arvalid;
  logic                   arready;
  logic [ID_W-1:0]        arid;
  logic [AXI_ADDR_W-1:0]  araddr;
  logic [AXI_LEN_W-1:0]   arlen;
  logic [AXI_SIZE_W-1:0]  arsize;
  logic [AXI_BURST_W-1:0] arburst;

  logic                   rvalid;
  logic                   rready;
  logic [ID_W-1:0]        rid;
  logic [AXI_DATA_W-1:0]  rdata;
  logic [AXI_RESP_W-1:0]  rresp;
  logic                   rlast;

  modport master (
    output awvalid, awid, awaddr, awlen, awsize, awburst,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bid, bresp,
    output bready,
    output arvalid, arid, araddr, arlen, arsize, arburst,
    input  arready,
    input  rvalid, rid, rdata, rresp, rlast,
    output rready
  );

  modport slave (
    input  awvalid, awid, awaddr, awlen, awsize, awburst,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bid, bresp,
    input  bready,
    input  arvalid, arid, araddr, arlen, arsize, arburst,
    output arready,
    output rvalid, rid, rdata, rresp, rlast,
    input  rready
  );

endinterface

// File: rtl/axi_ram_array.sv
// 1R1W synchronous RAM, DEPTH x 64 with byte enables; read-first, registered output.
// Read data appears one cycle after re and holds while re is low (no backpressure of its own).
module axi_ram_array #(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [63:0]   wdata,
  input  logic [7:0]    wstrb,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [63:0]   rdata
);

  logic [63:0] mem [DEPTH];
  logic [63:0] rdata_d, rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 8; b++) begin
        if (wstrb[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Same-cycle read of a word being written sees the pre-write contents.
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[raddr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/axi_ram_slave.sv
// AXI4 RAM responder: independent write (AW/W/B) and read (AR/R) FSMs over a 64-bit RAM; bursts under AXI_SLV_BURST_EN.
// Write: wready the cycle after AW, bvalid the cycle after the last W; read data one cycle after AR; B/R held under backpressure.
module axi_ram_slave
  import axi_ram_slave_pkg::*;
#(
  parameter logic [63:0] MEM_BASE  = 64'h0000_0000_8000_0000,
  parameter int          MEM_DEPTH = 4096,
  parameter int          ID_W      = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  axi_ram_slave_if.slave axi
);

  localparam int          IDX_W     = $clog2(MEM_DEPTH);
  localparam logic [63:0] MEM_BYTES = 64'(MEM_DEPTH) << 3;

  function automatic logic [IDX_W-1:0] word_index(input logic [63:0] addr);
    return IDX_W'((addr - MEM_BASE) >> 3);
  endfunction

  // Write channel state
  wr_state_e        w_state_d, w_state_q;
  logic [ID_W-1:0]  wid_d, wid_q;
  logic [IDX_W-1:0] widx_d, widx_q;
  logic             woor_d, woor_q;
  logic             werr_d, werr_q;
  logic [1:0]       bresp_d, bresp_q;
  logic             w_last_beat;
  logic [IDX_W-1:0] w_step;

  // Read channel state
  rd_state_e        r_state_d, r_state_q;
  logic [ID_W-1:0]  rid_d, rid_q;
  logic [IDX_W-1:0] ridx_d, ridx_q;
  logic             roor_d, roor_q;
  logic             r_last_beat;
  logic [IDX_W-1:0] r_step;

  logic             ram_we, ram_re;
  logic [IDX_W-1:0] ram_raddr;
  logic [63:0]      ram_rdata;

`ifdef AXI_SLV_BURST_EN
  logic [7:0] wlen_d, wlen_q, wcnt_d, wcnt_q;
  logic [7:0] rlen_d, rlen_q, rcnt_d, rcnt_q;
  logic       wstep_d, wstep_q, rstep_d, rstep_q;

  assign w_last_beat = (wcnt_q == wlen_q);
  assign r_last_beat = (rcnt_q == rlen_q);
  assign w_step      = wstep_q ? IDX_W'(1) : '0;
  assign r_step      = rstep_q ? IDX_W'(1) : '0;

  logic unused_sideband;
  assign unused_sideband = ^{axi.awsize, axi.arsize};
`else
  assign w_last_beat = 1'b1;
  assign r_last_beat = 1'b1;
  assign w_step      = IDX_W'(1);
  assign r_step      = IDX_W'(1);

  logic unused_sideband;
  assign unused_sideband = ^{axi.awsize, axi.arsize, axi.awlen, axi.arlen,
                             axi.awburst, axi.arburst};
`endif

  always_comb begin
    w_state_d    = w_state_q;
    wid_d        = wid_q;
    widx_d       = widx_q;
    woor_d       = woor_q;
    werr_d       = werr_q;
    bresp_d      = bresp_q;
    ram_we       = 1'b0;
    axi.awready  = 1'b0;
    axi.wready   = 1'b0;
    axi.bvalid   = 1'b0;
`ifdef AXI_SLV_BURST_EN
    wlen_d       = wlen_q;
    wcnt_d       = wcnt_q;
    wstep_d      = wstep_q;
`endif
    case (w_state_q)
      W_IDLE: begin
        axi.awready = 1'b1;
        if (axi.awvalid) begin
          wid_d     = axi.awid;
          widx_d    = word_index(axi.awaddr);
          woor_d    = !in_window(axi.awaddr, MEM_BASE, MEM_BYTES);
          werr_d    = 1'b0;
`ifdef AXI_SLV_BURST_EN
          wlen_d    = axi.awlen;
          wcnt_d    = '0;
          wstep_d   = (axi.awburst != BURST_FIXED);
`endif
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        axi.wready = 1'b1;
        if (axi.wvalid) begin
          ram_we = !woor_q;
          if (axi.wlast != w_last_beat) werr_d = 1'b1;
          widx_d = widx_q + w_step;
`ifdef AXI_SLV_BURST_EN
          wcnt_d = wcnt_q + 8'd1;
`endif
          if (w_last_beat) begin
            // Decode error outranks a framing error.
            bresp_d   = woor_q ? RESP_DECERR : (werr_d ? RESP_SLVERR : RESP_OKAY);
            w_state_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        axi.bvalid = 1'b1;
        if (axi.bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d   = r_state_q;
    rid_d       = rid_q;
    ridx_d      = ridx_q;
    roor_d      = roor_q;
    ram_re      = 1'b0;
    ram_raddr   = ridx_q;
    axi.arready = 1'b0;
`ifdef AXI_SLV_BURST_EN
    rlen_d      = rlen_q;
    rcnt_d      = rcnt_q;
    rstep_d     = rstep_q;
`endif
    case (r_state_q)
      R_IDLE: begin
        axi.arready = 1'b1;
        if (axi.arvalid) begin
          rid_d     = axi.arid;
          ridx_d    = word_index(axi.araddr);
          roor_d    = !in_window(axi.araddr, MEM_BASE, MEM_BYTES);
          ram_re    = 1'b1;
          ram_raddr = ridx_d;
`ifdef AXI_SLV_BURST_EN
          rlen_d    = axi.arlen;
          rcnt_d    = '0;
          rstep_d   = (axi.arburst != BURST_FIXED);
`endif
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (axi.rready) begin
          if (r_last_beat) begin
            r_state_d = R_IDLE;
          end else begin
            // Fetch the next beat only on acceptance so rdata holds while stalled.
            ridx_d    = ridx_q + r_step;
            ram_re    = 1'b1;
            ram_raddr = ridx_d;
`ifdef AXI_SLV_BURST_EN
            rcnt_d    = rcnt_q + 8'd1;
`endif
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q <= W_IDLE;
      wid_q     <= '0;
      widx_q    <= '0;
      woor_q    <= 1'b0;
      werr_q    <= 1'b0;
      bresp_q   <= RESP_OKAY;
      r_state_q <= R_IDLE;
      rid_q     <= '0;
      ridx_q    <= '0;
      roor_q    <= 1'b0;
`ifdef AXI_SLV_BURST_EN
      wlen_q    <= '0;
      wcnt_q    <= '0;
      wstep_q   <= 1'b0;
      rlen_q    <= '0;
      rcnt_q    <= '0;
      rstep_q   <= 1'b0;
`endif
    end else begin
      w_state_q <= w_state_d;
      wid_q     <= wid_d;
      widx_q    <= widx_d;
      woor_q    <= woor_d;
      werr_q    <= werr_d;
      bresp_q   <= bresp_d;
      r_state_q <= r_state_d;
      rid_q     <= rid_d;
      ridx_q    <= ridx_d;
      roor_q    <= roor_d;
`ifdef AXI_SLV_BURST_EN
      wlen_q    <= wlen_d;
      wcnt_q    <= wcnt_d;
      wstep_q   <= wstep_d;
      rlen_q    <= rlen_d;
      rcnt_q    <= rcnt_d;
      rstep_q   <= rstep_d;
`endif
    end
  end

  assign axi.bid    = wid_q;
  assign axi.bresp  = bresp_q;
  assign axi.rvalid = (r_state_q == R_DATA);
  assign axi.rid    = rid_q;
  assign axi.rresp  = roor_q ? RESP_DECERR : RESP_OKAY;
  assign axi.rdata  = roor_q ? '0 : ram_rdata;
  assign axi.rlast  = (r_state_q == R_DATA) && r_last_beat;

  axi_ram_array #(
    .DEPTH (MEM_DEPTH),
    .AW    (IDX_W)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (ram_we),
    .waddr (widx_q),
    .wdata (axi.wdata),
    .wstrb (axi.wstrb),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

endmodule

// File: doc/axi_ram_slave.md
# axi_ram_slave

AXI4 memory responder that terminates the core's AXI master port. It accepts write (AW/W/B) and read (AR/R) transactions on independent channels and services them from an internal 64-bit-wide byte-writable RAM. It sits on the bus side of the core, standing in for main memory in simulation and FPGA builds. It returns OKAY for in-range addresses and DECERR outside the window.

## Interface
Parameters:
- MEM_BASE, 64'h0000_0000_8000_0000, byte address of RAM word 0
- MEM_DEPTH, 4096, RAM depth in 64-bit words (power of two)
- ID_W, 4, width of AXI ID fields

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- awvalid/awready  in/out  1/1  write-address handshake
- awid  in  ID_W; awaddr  in  64; awlen  in  8; awsize  in  3; awburst  in  2
- wvalid/wready  in/out  1/1  write-data handshake
- wdata  in  64; wstrb  in  8  byte enables; wlast  in  1
- bvalid/bready  out/in  1/1  write-response handshake
- bid  out  ID_W; bresp  out  2
- arvalid/arready  in/out  1/1  read-address handshake
- arid  in  ID_W; araddr  in  64; arlen  in  8; arsize  in  3; arburst  in  2
- rvalid/rready  out/in  1/1  read-data handshake
- rid  out  ID_W; rdata  out  64; rresp  out  2; rlast  out  1
- The master's cache/prot/qos/region sideband signals are not connected.

## Operation
- Word index is (addr − MEM_BASE) >> 3. addr[2:0] is ignored. awsize/arsize are ignored; the beat stride is always 8 bytes.
- A transaction is in range iff MEM_BASE ≤ addr < MEM_BASE + 8·MEM_DEPTH, checked on the start address.
- Out of range: resp = 2'b11 (DECERR), writes are suppressed, rdata = 0. Otherwise resp = 2'b00.
- Write FSM:
  - W_IDLE: awready=1. On AW handshake, latch id, index, len, range flag → W_DATA.
  - W_DATA: wready=1. Each W handshake writes the strobed bytes and increments the index. The final beat (beat count == len) → W_RESP.
  - W_RESP: bvalid=1, held with bid/bresp stable until bready → W_IDLE.
- If wlast disagrees with the beat count, bresp = 2'b10 (SLVERR). DECERR takes precedence over SLVERR.
- Read FSM:
  - R_IDLE: arready=1. On AR handshake, issue a RAM read → R_DATA.
  - R_DATA: rvalid=1. On an R handshake of a non-last beat, issue the next read. On the last beat → R_IDLE.
- RAM output is held while no read is issued, so rdata stays stable under backpressure.
- The read and write channels are fully independent. A read and a write to the same word in the same cycle return the old data (read-first).
- rlast=1 on the beat where beat count == len.
- wstrb=8'h00 completes normally and writes nothing.

## Timing
- Reset values: awready=1, arready=1, wready=0, bvalid=0, bid=0, bresp=0, rvalid=0, rid=0, rdata=0, rresp=0, rlast=0.
- Reset mid-transaction returns both FSMs to IDLE and drops the transaction. RAM contents are not reset.
- Single write: AW handshake in cycle N, wready in N+1, bvalid in the cycle after the W handshake.
- Single read: AR handshake in cycle N, rvalid/rdata in N+1. If rready=1, arready returns in N+2, giving at most one read per 2 cycles.
- Burst read with rready held high: one beat per cycle, rvalid continuous.
- Index arithmetic wraps modulo MEM_DEPTH. A burst crossing the top of the window wraps to word 0.

## Configuration
- AXI_SLV_BURST_EN defined:
  - awlen/arlen honoured up to 256 beats.
  - awburst/arburst FIXED (2'b00) keeps the index constant; INCR (2'b01) and WRAP (2'b10) increment the index.
- AXI_SLV_BURST_EN undefined:
  - awlen/arlen are treated as 0.
  - A write ends after its first W beat; the wlast check is still applied to that beat.
  - Every read returns one beat with rlast=1.
  - Beat counters are not synthesized.

## Structure
- Shared package/define file holds:
  - response codes: RESP_OKAY 2'b00, RESP_SLVERR 2'b10, RESP_DECERR 2'b11
  - burst codes: FIXED, INCR, WRAP
  - FSM state encodings
  - the existing AXI bus-width defines
- Sub-module axi_ram_array: 1R1W synchronous RAM, MEM_DEPTH × 64, with byte write enables, read-first, output holds without a read enable.

## Test plan
- Write awaddr=MEM_BASE+8, wdata=64'h1122334455667788, wstrb=8'hFF, then read the same address → bresp=0; rdata=64'h1122334455667788 one cycle after the AR handshake, rresp=0, rlast=1.
- Write wstrb=8'h0F, wdata=64'hFFFFFFFF_AAAAAAAA over that word, then read → rdata=64'h11223344_AAAAAAAA.
- Read araddr=MEM_BASE−8 → rresp=2'b11, rdata=0. Write to the same address → bresp=2'b11, RAM unchanged.
- Single write with bready held low for 5 cycles → bvalid, bid, bresp stable throughout; awready stays 0 until the B handshake.
- With AXI_SLV_BURST_EN: INCR burst write, awlen=3, then INCR read, arlen=3, rready toggling 1/0 → 4 beats in order, rdata stable while stalled, rlast on the 4th beat only.
- Simultaneous read and write to the same word, then assert rst_n=0 mid-burst → the read returns old data; after reset both FSMs are idle with awready=arready=1, and RAM contents are retained.
